// File: rtl/ipd_trunc.sv
// I-PD servo controller: integral on error r-y, P and D on measurement y, 8-bit actuator command out.
// Latency: trunc updates 7 enabled clock edges after the edge that accepts listo; one shared multiplier.
// Backpressure: listo is ignored while busy or while en=0 (no queueing); en=0 freezes all state.
// Build option: define IPD_SAT_EN to clamp u to [0, 255.0] (anti-windup); otherwise u wraps.
module ipd_trunc #(
    parameter logic signed [15:0] KP    = 16'sh0100,
    parameter logic signed [15:0] KI    = 16'sh0080,
    parameter logic signed [15:0] KD    = 16'sh0040,
    parameter int                 FRAC  = 8,
    parameter int                 ACC_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        listo,
    input  logic [10:0] r,
    input  logic [10:0] y,
    output logic [7:0]  trunc
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DIFF  = 3'd1,
        MUL_I = 3'd2,
        MUL_P = 3'd3,
        MUL_D = 3'd4,
        LIMIT = 3'd5,
        OUT   = 3'd6
    } state_t;

    state_t state, state_nxt;

    logic        [10:0]       r_q, y_q, y1, y2;
    logic signed [12:0]       e, d1, d2;
    logic signed [ACC_W-1:0]  acc, u, lim;
    logic        [7:0]        cmd;

    logic signed [15:0]       coef;
    logic signed [12:0]       opnd;
    logic signed [28:0]       prod;
    logic signed [ACC_W-1:0]  prod_ext;

    // Differences are formed on zero-extended 13-bit values; all results fit a 13-bit signed range.
    logic signed [12:0] e_w, d1_w, d2_w;
    assign e_w  = $signed({2'b00, r_q}) - $signed({2'b00, y_q});
    assign d1_w = $signed({2'b00, y_q}) - $signed({2'b00, y1});
    assign d2_w = $signed({2'b00, y_q} - {1'b0, y1, 1'b0} + {2'b00, y2});

    // Select the gain/operand pair for the single shared multiplier from the current state.
    always_comb begin
        coef = KI;
        opnd = e;
        case (state)
            MUL_P:   begin coef = KP; opnd = d1; end
            MUL_D:   begin coef = KD; opnd = d2; end
            default: begin coef = KI; opnd = e;  end
        endcase
    end

    // Q8.8 gain times integer difference lands directly in the Q(FRAC) accumulator scale.
    assign prod     = 29'(coef) * 29'(opnd);
    assign prod_ext = ACC_W'(prod);

`ifdef IPD_SAT_EN
    localparam logic signed [ACC_W-1:0] UMAX = ACC_W'(255 << FRAC);

    // Clamp the new effort to the actuator range; the clamped value becomes the stored u.
    always_comb begin
        lim = acc;
        if (acc < 0)
            lim = '0;
        else if (acc > UMAX)
            lim = UMAX;
    end
`else
    // No clamp: u wraps modulo 2^ACC_W and the command is the raw integer byte.
    always_comb begin
        lim = acc;
    end
`endif

    // Next-state sequencing; en=0 holds the current state.
    always_comb begin
        state_nxt = state;
        if (en) begin
            case (state)
                IDLE:    if (listo) state_nxt = DIFF;
                DIFF:    state_nxt = MUL_I;
                MUL_I:   state_nxt = MUL_P;
                MUL_P:   state_nxt = MUL_D;
                MUL_D:   state_nxt = LIMIT;
                LIMIT:   state_nxt = OUT;
                OUT:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Datapath: operand capture, multiply-accumulate sequence, history shift and command output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q   <= '0;
            y_q   <= '0;
            y1    <= '0;
            y2    <= '0;
            e     <= '0;
            d1    <= '0;
            d2    <= '0;
            acc   <= '0;
            u     <= '0;
            cmd   <= '0;
            trunc <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (listo) begin
                        r_q <= r;
                        y_q <= y;
                    end
                end
                DIFF: begin
                    e   <= e_w;
                    d1  <= d1_w;
                    d2  <= d2_w;
                    acc <= u;
                end
                MUL_I: acc <= acc + prod_ext;
                MUL_P: acc <= acc - prod_ext;
                MUL_D: acc <= acc - prod_ext;
                LIMIT: begin
                    u  <= lim;
                    y2 <= y1;
                    y1 <= y_q;
                end
                OUT:     cmd <= u[FRAC+7:FRAC];
                default: ;
            endcase
            // Registered output stage keeps the actuator command glitch-free.
            trunc <= cmd;
        end
    end

endmodule

// File: tb/tb_ipd_trunc.sv
module tb_ipd_trunc;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        listo;
    logic [10:0] r;
    logic [10:0] y;
    logic [7:0]  trunc;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: effort in units of 1/256, plus measurement history.
    longint m_u;
    longint m_y1;
    longint m_y2;
    logic [7:0] m_trunc;

    localparam longint GKP = 256;
    localparam longint GKI = 128;
    localparam longint GKD = 64;

    ipd_trunc dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .listo (listo),
        .r     (r),
        .y     (y),
        .trunc (trunc)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_u = 0; m_y1 = 0; m_y2 = 0; m_trunc = 8'd0;
    endtask

    task automatic model_step(input longint rv, input longint yv);
        m_u = m_u + GKI * (rv - yv) - GKP * (yv - m_y1) - GKD * (yv - 2 * m_y1 + m_y2);
`ifdef IPD_SAT_EN
        if (m_u < 0) m_u = 0;
        if (m_u > 255 * 256) m_u = 255 * 256;
`else
        m_u = longint'(int'(m_u));
`endif
        m_y2 = m_y1;
        m_y1 = yv;
        m_trunc = 8'((m_u >>> 8) & 255);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; en = 1'b1; listo = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // One strobed update; optionally stalls en for stall_len edges after edge stall_at,
    // and optionally strobes listo with junk operands while the controller is busy.
    task automatic run_update(input logic [10:0] rv, input logic [10:0] yv, input int stall_at,
                              input int stall_len, input bit extra, input string name);
        logic [7:0] prev, exp;
        int total;
        prev = m_trunc;
        model_step(longint'(rv), longint'(yv));
        exp = m_trunc;
        total = 7 + ((stall_at >= 0) ? stall_len : 0);
        @(negedge clk);
        r = rv; y = yv; listo = 1'b1; en = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            listo = extra && (k == 1 || k == 3 || k == 5);
            if (extra) begin
                r = 11'($urandom);
                y = 11'($urandom);
            end
            en = !(stall_at >= 0 && k > stall_at && k <= stall_at + stall_len);
            if (k == total) begin
                n_tests++;
                if (trunc !== prev) begin
                    n_fail++;
                    $display("FAIL %s early: trunc=%0d expected %0d one edge before update", name, trunc, prev);
                end
            end
            @(posedge clk);
        end
        #1;
        n_tests++;
        if (trunc !== exp) begin
            n_fail++;
            $display("FAIL %s: trunc=%0d expected %0d", name, trunc, exp);
        end
        @(negedge clk);
        listo = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (trunc !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_initial: trunc=%0d expected 0", trunc);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (trunc !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_held: trunc=%0d expected 0", trunc);
        end
    endtask

    task automatic test_integration();
        int n;
        do_reset();
`ifdef IPD_SAT_EN
        n = 7;
`else
        n = 6;
`endif
        for (int i = 0; i < n; i++)
            run_update(11'd100, 11'd0, -1, 0, 1'b0, $sformatf("integ_%0d", i + 1));
    endtask

    task automatic test_pd();
        do_reset();
        run_update(11'd100, 11'd0, -1, 0, 1'b0, "pd_first");
        run_update(11'd100, 11'd10, -1, 0, 1'b0, "pd_step");
    endtask

    task automatic test_negative();
        do_reset();
        run_update(11'd0, 11'd0, -1, 0, 1'b0, "neg_zero");
        run_update(11'd0, 11'd100, -1, 0, 1'b0, "neg_effort");
    endtask

    task automatic test_busy();
        logic [7:0] hold;
        do_reset();
        run_update(11'd100, 11'd0, -1, 0, 1'b1, "busy_update");
        hold = m_trunc;
        repeat (12) @(posedge clk);
        #1;
        n_tests++;
        if (trunc !== hold) begin
            n_fail++;
            $display("FAIL busy_no_extra: trunc=%0d expected %0d", trunc, hold);
        end
    endtask

    task automatic test_enable();
        do_reset();
        run_update(11'd100, 11'd0, -1, 0, 1'b0, "en_first");
        run_update(11'd100, 11'd10, 3, 5, 1'b0, "en_stall");
        // listo with en=0 must not be latched
        @(negedge clk);
        en = 1'b0; listo = 1'b1; r = 11'd900; y = 11'd5;
        repeat (3) @(negedge clk);
        en = 1'b1; listo = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n_tests++;
        if (trunc !== m_trunc) begin
            n_fail++;
            $display("FAIL en_listo_ignored: trunc=%0d expected %0d", trunc, m_trunc);
        end
    endtask

    task automatic test_random();
        int sa, sl;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            sa = -1; sl = 0;
            if ($urandom_range(2) == 0) begin
                sa = int'($urandom_range(6));
                sl = int'($urandom_range(4, 1));
            end
            run_update(11'($urandom), 11'($urandom), sa, sl, 1'($urandom_range(1)),
                       $sformatf("rand_%0d", i));
            repeat ($urandom_range(3)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_update(11'd200, 11'd0, -1, 0, 1'b0, "midrst_pre");
        @(negedge clk);
        r = 11'd50; y = 11'd0; listo = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        listo = 1'b0;
        rst = 1'b0;
        #1;
        n_tests++;
        if (trunc !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_async: trunc=%0d expected 0", trunc);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        run_update(11'd100, 11'd0, -1, 0, 1'b0, "midrst_after");
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; listo = 1'b0; r = '0; y = '0;
        model_reset();
        test_reset();
        test_integration();
        test_pd();
        test_negative();
        test_busy();
        test_enable();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
